decode_hazard_ctrl: RTL and testbench

Decode-stage controller for the 5-stage pipeline. It owns the IF/ID and ID/EX control registers and decodes the opcode into ImmSrcD, which drives the immediate extender (00 I, 01 S, 10 B, 11 J). It detects load-use hazards and stalls fetch, flushes on taken branches, and counts inserted bubbles.

---
 rtl/decode_hazard_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_decode_hazard_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// decode_hazard_ctrl
//
// Decode-stage controller for the 5-stage pipeline. It owns the IF/ID and ID/EX
// pipeline registers, decodes the opcode held in IF/ID and selects the immediate
// format for the extender. It also stalls fetch on a load-use hazard, flushes
// both registers on a taken branch, and keeps a saturating count of the bubbles
// it inserts into ID/EX.
//
// Optional feature macro: JAL_EN
//   defined   : opcode 1101111 (JAL) decodes as a J-type jump and JumpE is registered
//   undefined : JAL is treated as illegal and JumpE is tied low
//
// Parameters
//   ADDR_W  PC width
//   CNT_W   bubble counter width
//
// Ports
//   clk         clock, rising edge
//   rst         asynchronous active-low reset
//   InstrF      fetched instruction
//   PCF         fetched PC
//   ValidF      fetch slot valid
//   PCSrcE      branch/jump taken, resolved in EX
//   StallF      hold PC and fetch (combinational)
//   InstrD      IF/ID instruction
//   PCD         IF/ID PC
//   ImmSrcD     immediate select, 00 I / 01 S / 10 B / 11 J (combinational)
//   IllegalD    valid IF/ID slot holding an unrecognised opcode (combinational)
//   ValidE      ID/EX slot valid
//   RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE   ID/EX controls
//   ResultSrcE  00 ALU, 01 memory, 10 PC+4
//   RdE, Rs1E, Rs2E   ID/EX register indices
//   BubbleCnt   saturating count of bubbles inserted into ID/EX
// -----------------------------------------------------------------------------
module decode_hazard_ctrl #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       InstrF,
  input  logic [ADDR_W-1:0] PCF,
  input  logic              ValidF,
  input  logic              PCSrcE,
  output logic              StallF,
  output logic [31:0]       InstrD,
  output logic [ADDR_W-1:0] PCD,
  output logic [1:0]        ImmSrcD,
  output logic              IllegalD,
  output logic              ValidE,
  output logic              RegWriteE,
  output logic              MemWriteE,
  output logic              ALUSrcE,
  output logic              BranchE,
  output logic              JumpE,
  output logic [1:0]        ResultSrcE,
  output logic [4:0]        RdE,
  output logic [4:0]        Rs1E,
  output logic [4:0]        Rs2E,
  output logic [CNT_W-1:0]  BubbleCnt
);

  // IF/ID register
  logic              validD_q;
  logic [31:0]       instrD_q;
  logic [ADDR_W-1:0] pcD_q;

  // ID/EX register
  logic              validE_q;
  logic              regWriteE_q;
  logic              memWriteE_q;
  logic              aluSrcE_q;
  logic              branchE_q;
  logic [1:0]        resultSrcE_q;
  logic [4:0]        rdE_q;
  logic [4:0]        rs1E_q;
  logic [4:0]        rs2E_q;
  logic [CNT_W-1:0]  bubbleCnt_q;
  logic [CNT_W-1:0]  bubbleCnt_d;

  // Raw decode of the IF/ID instruction
  logic [1:0] immSrcD;
  logic       regWriteD;
  logic       memWriteD;
  logic [1:0] resultSrcD;
  logic       aluSrcD;
  logic       branchD;
  logic       knownD;
`ifdef JAL_EN
  logic       jumpD;
  logic       jumpE_q;
`endif

  logic [4:0] rs1D;
  logic [4:0] rs2D;
  logic [4:0] rdD;
  logic       lwStall;

  assign rs1D = instrD_q[19:15];
  assign rs2D = instrD_q[24:20];
  assign rdD  = instrD_q[11:7];

  // Opcode decode; anything not listed leaves every control low
  always_comb begin
    immSrcD    = 2'b00;
    regWriteD  = 1'b0;
    memWriteD  = 1'b0;
    resultSrcD = 2'b00;
    aluSrcD    = 1'b0;
    branchD    = 1'b0;
    knownD     = 1'b1;
`ifdef JAL_EN
    jumpD      = 1'b0;
`endif
    case (instrD_q[6:0])
      7'b0000011: begin
        regWriteD  = 1'b1;
        resultSrcD = 2'b01;
        aluSrcD    = 1'b1;
      end
      7'b0100011: begin
        immSrcD   = 2'b01;
        memWriteD = 1'b1;
        aluSrcD   = 1'b1;
      end
      7'b0110011: begin
        regWriteD = 1'b1;
      end
      7'b0010011: begin
        regWriteD = 1'b1;
        aluSrcD   = 1'b1;
      end
      7'b1100011: begin
        immSrcD = 2'b10;
        branchD = 1'b1;
      end
`ifdef JAL_EN
      7'b1101111: begin
        immSrcD    = 2'b11;
        regWriteD  = 1'b1;
        resultSrcD = 2'b10;
        jumpD      = 1'b1;
      end
`endif
      default: knownD = 1'b0;
    endcase
  end

  // Rs2 is compared for every opcode, even those without an rs2 field: a
  // spurious one-cycle stall is harmless, a missed hazard is not.
  assign lwStall = validD_q & validE_q & (resultSrcE_q == 2'b01) & (rdE_q != 5'd0) &
                   ((rdE_q == rs1D) | (rdE_q == rs2D));

  // A taken branch discards the stalled instruction anyway, so it suppresses the stall
  assign StallF = lwStall & ~PCSrcE;

  assign bubbleCnt_d = (bubbleCnt_q == {CNT_W{1'b1}}) ? bubbleCnt_q
                                                     : bubbleCnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

  // Pipeline registers: flush beats load-use stall, which beats normal advance
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      validD_q     <= 1'b0;
      instrD_q     <= '0;
      pcD_q        <= '0;
      validE_q     <= 1'b0;
      regWriteE_q  <= 1'b0;
      memWriteE_q  <= 1'b0;
      aluSrcE_q    <= 1'b0;
      branchE_q    <= 1'b0;
      resultSrcE_q <= 2'b00;
      rdE_q        <= '0;
      rs1E_q       <= '0;
      rs2E_q       <= '0;
      bubbleCnt_q  <= '0;
`ifdef JAL_EN
      jumpE_q      <= 1'b0;
`endif
    end else if (PCSrcE || lwStall) begin
      // Both cases put a bubble into ID/EX; only a flush also empties IF/ID
      if (PCSrcE) begin
        validD_q <= 1'b0;
        instrD_q <= '0;
        pcD_q    <= '0;
      end
      validE_q     <= 1'b0;
      regWriteE_q  <= 1'b0;
      memWriteE_q  <= 1'b0;
      aluSrcE_q    <= 1'b0;
      branchE_q    <= 1'b0;
      resultSrcE_q <= 2'b00;
      rdE_q        <= '0;
      rs1E_q       <= '0;
      rs2E_q       <= '0;
      bubbleCnt_q  <= bubbleCnt_d;
`ifdef JAL_EN
      jumpE_q      <= 1'b0;
`endif
    end else begin
      validD_q     <= ValidF;
      instrD_q     <= InstrF;
      pcD_q        <= PCF;
      validE_q     <= validD_q;
      regWriteE_q  <= regWriteD & validD_q;
      memWriteE_q  <= memWriteD & validD_q;
      aluSrcE_q    <= aluSrcD & validD_q;
      branchE_q    <= branchD & validD_q;
      resultSrcE_q <= resultSrcD & {2{validD_q}};
      rdE_q        <= rdD;
      rs1E_q       <= rs1D;
      rs2E_q       <= rs2D;
`ifdef JAL_EN
      jumpE_q      <= jumpD & validD_q;
`endif
    end
  end

  assign InstrD     = instrD_q;
  assign PCD        = pcD_q;
  assign ImmSrcD    = immSrcD;
  assign IllegalD   = validD_q & ~knownD;
  assign ValidE     = validE_q;
  assign RegWriteE  = regWriteE_q;
  assign MemWriteE  = memWriteE_q;
  assign ALUSrcE    = aluSrcE_q;
  assign BranchE    = branchE_q;
  assign ResultSrcE = resultSrcE_q;
  assign RdE        = rdE_q;
  assign Rs1E       = rs1E_q;
  assign Rs2E       = rs2E_q;
  assign BubbleCnt  = bubbleCnt_q;
`ifdef JAL_EN
  assign JumpE      = jumpE_q;
`else
  assign JumpE      = 1'b0;
`endif

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_decode_hazard_ctrl
//
// Self-checking bench for decode_hazard_ctrl. Two instances share the same
// stimulus: one with the default counter width and one with a 2-bit counter
// so that saturation is reached quickly. A pipeline-slot model kept here
// predicts every output each cycle; directed sequences add literal checks.
// Honours JAL_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_decode_hazard_ctrl;

  typedef struct packed {
    logic [1:0] imm;
    logic       rw;
    logic       mw;
    logic [1:0] rs;
    logic       alu;
    logic       br;
    logic       jmp;
    logic       legal;
  } dec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] InstrF = '0;
  logic [31:0] PCF = '0;
  logic        ValidF = 1'b0;
  logic        PCSrcE = 1'b0;

  logic        StallF, IllegalD, ValidE, RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE;
  logic [31:0] InstrD, PCD;
  logic [1:0]  ImmSrcD, ResultSrcE;
  logic [4:0]  RdE, Rs1E, Rs2E;
  logic [15:0] BubbleCnt;

  logic        sStallF, sIllegalD, sValidE, sRegWriteE, sMemWriteE, sALUSrcE, sBranchE, sJumpE;
  logic [31:0] sInstrD, sPCD;
  logic [1:0]  sImmSrcD, sResultSrcE;
  logic [4:0]  sRdE, sRs1E, sRs2E;
  logic [1:0]  sBubbleCnt;

  int checks = 0;
  int errors = 0;

  // Model state: contents of the D and E slots plus the number of bubbles
  logic        mValidD;
  logic [31:0] mInstrD;
  logic [31:0] mPcD;
  logic        mValidE;
  dec_t        mE;
  logic [4:0]  mRdE, mRs1E, mRs2E;
  int          mBubbles;

  decode_hazard_ctrl #(.ADDR_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .InstrF(InstrF), .PCF(PCF), .ValidF(ValidF), .PCSrcE(PCSrcE),
    .StallF(StallF), .InstrD(InstrD), .PCD(PCD), .ImmSrcD(ImmSrcD), .IllegalD(IllegalD),
    .ValidE(ValidE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ALUSrcE(ALUSrcE),
    .BranchE(BranchE), .JumpE(JumpE), .ResultSrcE(ResultSrcE), .RdE(RdE), .Rs1E(Rs1E),
    .Rs2E(Rs2E), .BubbleCnt(BubbleCnt)
  );

  decode_hazard_ctrl #(.ADDR_W(32), .CNT_W(2)) dutSat (
    .clk(clk), .rst(rst), .InstrF(InstrF), .PCF(PCF), .ValidF(ValidF), .PCSrcE(PCSrcE),
    .StallF(sStallF), .InstrD(sInstrD), .PCD(sPCD), .ImmSrcD(sImmSrcD), .IllegalD(sIllegalD),
    .ValidE(sValidE), .RegWriteE(sRegWriteE), .MemWriteE(sMemWriteE), .ALUSrcE(sALUSrcE),
    .BranchE(sBranchE), .JumpE(sJumpE), .ResultSrcE(sResultSrcE), .RdE(sRdE), .Rs1E(sRs1E),
    .Rs2E(sRs2E), .BubbleCnt(sBubbleCnt)
  );

  // Free-running clock, period 10
  always #5 clk = ~clk;

  // Opcode table: what each instruction class must drive
  function automatic dec_t decodeOp(input logic [6:0] op);
    dec_t d;
    d = '0;
    d.legal = 1'b1;
    case (op)
      7'b0000011: begin d.rw = 1'b1; d.rs = 2'b01; d.alu = 1'b1; end
      7'b0100011: begin d.imm = 2'b01; d.mw = 1'b1; d.alu = 1'b1; end
      7'b0110011: begin d.rw = 1'b1; end
      7'b0010011: begin d.rw = 1'b1; d.alu = 1'b1; end
      7'b1100011: begin d.imm = 2'b10; d.br = 1'b1; end
`ifdef JAL_EN
      7'b1101111: begin d.imm = 2'b11; d.rw = 1'b1; d.rs = 2'b10; d.jmp = 1'b1; end
`endif
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

  function automatic logic modelLoadUse();
    logic [4:0] s1, s2;
    s1 = mInstrD[19:15];
    s2 = mInstrD[24:20];
    return mValidD && mValidE && (mE.rs == 2'b01) && (mRdE != 5'd0) &&
           ((mRdE == s1) || (mRdE == s2));
  endfunction

  task automatic resetModel();
    mValidD = 1'b0; mInstrD = '0; mPcD = '0;
    mValidE = 1'b0; mE = '0; mRdE = '0; mRs1E = '0; mRs2E = '0;
    mBubbles = 0;
  endtask

  task automatic clearE();
    mValidE = 1'b0; mE = '0; mRdE = '0; mRs1E = '0; mRs2E = '0;
  endtask

  // Advance the model by one rising edge using the inputs that were applied
  task automatic modelUpdate();
    dec_t d;
    if (!rst) begin
      resetModel();
    end else if (PCSrcE) begin
      mValidD = 1'b0; mInstrD = '0; mPcD = '0;
      clearE();
      mBubbles++;
    end else if (modelLoadUse()) begin
      clearE();
      mBubbles++;
    end else begin
      d = decodeOp(mInstrD[6:0]);
      mValidE = mValidD;
      mE      = mValidD ? d : '0;
      mE.legal = 1'b0;
      mRdE  = mInstrD[11:7];
      mRs1E = mInstrD[19:15];
      mRs2E = mInstrD[24:20];
      mValidD = ValidF; mInstrD = InstrF; mPcD = PCF;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Compare one instance's outputs against the model
  task automatic checkSet(input string tag, input logic st, input logic [31:0] iD,
                          input logic [31:0] pD, input logic [1:0] imm, input logic ill,
                          input logic vE, input logic rw, input logic mw, input logic alu,
                          input logic br, input logic jp, input logic [1:0] rs,
                          input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2,
                          input logic [15:0] cnt, input int cntMax);
    dec_t dD;
    dD = decodeOp(mInstrD[6:0]);
    chk({tag, "StallF"},     st,  modelLoadUse() && !PCSrcE);
    chk({tag, "InstrD"},     iD,  mInstrD);
    chk({tag, "PCD"},        pD,  mPcD);
    chk({tag, "ImmSrcD"},    imm, dD.imm);
    chk({tag, "IllegalD"},   ill, mValidD && !dD.legal);
    chk({tag, "ValidE"},     vE,  mValidE);
    chk({tag, "RegWriteE"},  rw,  mE.rw);
    chk({tag, "MemWriteE"},  mw,  mE.mw);
    chk({tag, "ALUSrcE"},    alu, mE.alu);
    chk({tag, "BranchE"},    br,  mE.br);
    chk({tag, "JumpE"},      jp,  mE.jmp);
    chk({tag, "ResultSrcE"}, rs,  mE.rs);
    chk({tag, "RdE"},        rd,  mRdE);
    chk({tag, "Rs1E"},       r1,  mRs1E);
    chk({tag, "Rs2E"},       r2,  mRs2E);
    chk({tag, "BubbleCnt"},  cnt, (mBubbles > cntMax) ? cntMax : mBubbles);
  endtask

  task automatic checkOutput();
    checkSet("main.", StallF, InstrD, PCD, ImmSrcD, IllegalD, ValidE, RegWriteE, MemWriteE,
             ALUSrcE, BranchE, JumpE, ResultSrcE, RdE, Rs1E, Rs2E, BubbleCnt, 65535);
    checkSet("sat.", sStallF, sInstrD, sPCD, sImmSrcD, sIllegalD, sValidE, sRegWriteE,
             sMemWriteE, sALUSrcE, sBranchE, sJumpE, sResultSrcE, sRdE, sRs1E, sRs2E,
             {14'd0, sBubbleCnt}, 3);
  endtask

  task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc,
                               input logic valid, input logic taken);
    InstrF = instr; PCF = pc; ValidF = valid; PCSrcE = taken;
  endtask

  // One full cycle: drive on the falling edge, compare, then step the model
  task automatic doCycle(input logic [31:0] instr, input logic [31:0] pc,
                         input logic valid, input logic taken);
    @(negedge clk);
    applyStimulus(instr, pc, valid, taken);
    #1 checkOutput();
    @(posedge clk);
    modelUpdate();
  endtask

  localparam logic [31:0] LW  = 32'h0000A283;
  localparam logic [31:0] ADD = 32'h00028333;
  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] SW  = 32'h0020A423;
  localparam logic [31:0] BEQ = 32'h00000063;
  localparam logic [31:0] JAL = 32'h0000006F;

  initial begin
    logic [6:0]  ops [8];
    logic [31:0] instr;
    resetModel();

    // Reset held with busy inputs
    applyStimulus(32'hFFFFFFFF, 32'hDEADBEEF, 1'b1, 1'b0);
    repeat (3) doCycle(32'hFFFFFFFF, 32'hDEADBEEF, 1'b1, 1'b0);
    #1;
    chk("rstInstrD", InstrD, 0);
    chk("rstValidE", ValidE, 0);
    chk("rstBubbleCnt", BubbleCnt, 0);
    rst = 1'b1;

    // First load reaches D, then E
    doCycle(LW, 32'h100, 1'b1, 1'b0);
    #1;
    chk("lwInD", InstrD, LW);
    chk("lwImmSrcD", ImmSrcD, 2'b00);
    doCycle(ADD, 32'h104, 1'b1, 1'b0);
    #1;
    chk("lwValidE", ValidE, 1);
    chk("lwResultSrcE", ResultSrcE, 2'b01);
    chk("lwRdE", RdE, 5);
    chk("loadUseStallF", StallF, 1);

    // The stall cycle: add held in D, bubble in E
    doCycle(NOP, 32'h108, 1'b1, 1'b0);
    #1;
    chk("stallHoldInstrD", InstrD, ADD);
    chk("bubbleValidE", ValidE, 0);
    chk("bubbleCnt1", BubbleCnt, 1);
    chk("stallOneCycle", StallF, 0);
    doCycle(NOP, 32'h108, 1'b1, 1'b0);
    #1;
    chk("addRdE", RdE, 6);
    chk("addValidE", ValidE, 1);

    // Store and branch
    doCycle(SW, 32'h10C, 1'b1, 1'b0);
    #1 chk("swImmSrcD", ImmSrcD, 2'b01);
    doCycle(BEQ, 32'h110, 1'b1, 1'b0);
    #1;
    chk("swMemWriteE", MemWriteE, 1);
    chk("swALUSrcE", ALUSrcE, 1);
    chk("swRegWriteE", RegWriteE, 0);
    chk("beqImmSrcD", ImmSrcD, 2'b10);
    doCycle(NOP, 32'h114, 1'b1, 1'b0);
    #1 chk("beqBranchE", BranchE, 1);

    // Flush and load-use hazard in the same cycle
    doCycle(LW, 32'h200, 1'b1, 1'b0);
    doCycle(ADD, 32'h204, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(NOP, 32'h208, 1'b1, 1'b1);
    #1 checkOutput();
    chk("flushStallF", StallF, 0);
    @(posedge clk);
    modelUpdate();
    #1;
    chk("flushInstrD", InstrD, 0);
    chk("flushValidE", ValidE, 0);
    chk("flushBubbleCnt", BubbleCnt, 2);

    // JAL
    doCycle(JAL, 32'h300, 1'b1, 1'b0);
    #1;
`ifdef JAL_EN
    chk("jalImmSrcD", ImmSrcD, 2'b11);
    chk("jalIllegalD", IllegalD, 0);
`else
    chk("jalImmSrcD", ImmSrcD, 2'b00);
    chk("jalIllegalD", IllegalD, 1);
`endif
    doCycle(NOP, 32'h304, 1'b1, 1'b0);
    #1;
`ifdef JAL_EN
    chk("jalJumpE", JumpE, 1);
    chk("jalResultSrcE", ResultSrcE, 2'b10);
    chk("jalRegWriteE", RegWriteE, 1);
`else
    chk("jalJumpE", JumpE, 0);
    chk("jalResultSrcE", ResultSrcE, 2'b00);
    chk("jalRegWriteE", RegWriteE, 0);
`endif

    // Three more load-use stalls: 5 bubbles total, 2-bit counter pinned at 3
    for (int k = 0; k < 3; k++) begin
      doCycle(LW, 32'h400, 1'b1, 1'b0);
      doCycle(ADD, 32'h404, 1'b1, 1'b0);
      doCycle(NOP, 32'h408, 1'b1, 1'b0);
      doCycle(NOP, 32'h408, 1'b1, 1'b0);
    end
    #1;
    chk("cnt5", BubbleCnt, 5);
    chk("satCnt3", sBubbleCnt, 3);

    // Asynchronous reset in the middle of a stall
    doCycle(LW, 32'h500, 1'b1, 1'b0);
    doCycle(ADD, 32'h504, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(NOP, 32'h508, 1'b1, 1'b0);
    #2 rst = 1'b0;
    #1 resetModel();
    checkOutput();
    chk("midRstStallF", StallF, 0);
    chk("midRstBubbleCnt", BubbleCnt, 0);
    @(posedge clk);
    modelUpdate();
    #1 rst = 1'b1;

    // Randomized traffic with small register indices to provoke hazards
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
            7'b1100011, 7'b1101111, 7'b0110111, 7'b0000000};
    for (int n = 0; n < 600; n++) begin
      instr        = $urandom;
      instr[6:0]   = ops[$urandom_range(0, 7)];
      instr[11:7]  = 5'($urandom_range(0, 3));
      instr[19:15] = 5'($urandom_range(0, 3));
      instr[24:20] = 5'($urandom_range(0, 3));
      doCycle(instr, $urandom, ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
